a0_uart_tx: RTL and testbench



---
 rtl/a0_uart_tx.sv | 99 +++++++++
 tb/tb_a0_uart_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/a0_uart_tx.sv
// a0_uart_tx: queues every change of the core's a0 value and sends it LSB byte first as four 8N1 UART frames
`timescale 1ns/1ps
module a0_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         a0,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   FULL  = FIFO_DEPTH[PW:0];
    localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] prev_a0, shreg, shreg_next;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic [TW-1:0]         timer, timer_next;
    logic [2:0]            bit_idx, bit_idx_next;
    logic [1:0]            byte_idx, byte_idx_next;
    logic                  push_req, push, pop, tick;
    assign push_req = a0 != prev_a0;
    assign pop      = state == IDLE && count != '0;
    // a full FIFO still takes a push when the FSM drains a word on the same edge
    assign push     = push_req && (count != FULL || pop);
    assign tick     = timer == TLAST;
    assign tx       = state == DATA ? shreg[bit_idx] : state != START;
    assign busy     = state != IDLE || count != '0;
    assign level    = count;
    always_comb begin
        state_next    = state;
        timer_next    = tick ? '0 : timer + 1'b1;
        bit_idx_next  = bit_idx;
        byte_idx_next = byte_idx;
        shreg_next    = shreg;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (pop) begin
                    state_next    = START;
                    shreg_next    = mem[rd_ptr];
                    byte_idx_next = '0;
                end
            end
            START: if (tick) begin
                state_next   = DATA;
                bit_idx_next = '0;
            end
            DATA: if (tick) begin
                bit_idx_next = bit_idx + 3'd1;
                state_next   = bit_idx == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_next = byte_idx == 2'd3 ? IDLE : START;
                if (byte_idx != 2'd3) begin
                    byte_idx_next = byte_idx + 2'd1;
                    shreg_next    = shreg >> 8;
                end
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            prev_a0  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            bit_idx  <= bit_idx_next;
            byte_idx <= byte_idx_next;
            shreg    <= shreg_next;
            prev_a0  <= a0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            if (push_req && !push) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= a0;
    end
endmodule

// File: tb/tb_a0_uart_tx.sv
// tb_a0_uart_tx: table vectors for FIFO level/overflow plus a byte scoreboard checked by a UART frame monitor
`timescale 1ns/1ps
module tb_a0_uart_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a0;
    logic        tx, busy, overflow;
    logic [2:0]  level;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    a0_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a0(a0), .tx(tx),
        .busy(busy), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a0;
        bit          push;
        int          lvl;
        bit          ovf;
        bit          bsy;
    } vec_t;
    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [39:0] frame(input logic [7:0] b);
        logic [9:0]  s = {1'b1, b, 1'b0};
        logic [39:0] r;
        for (int c = 0; c < 40; c++) r[c] = s[c/4];
        return r;
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    endtask

    task automatic drain(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("drain", 64'(i < max), 1);
    endtask

    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            a0 = tv[i].a0;
            if (tv[i].push) push_word(tv[i].a0);
            @(negedge clk);
            chk({tag, "_level"}, level, tv[i].lvl);
            chk({tag, "_ovf"}, overflow, tv[i].ovf);
            chk({tag, "_busy"}, busy, tv[i].bsy);
        end
    endtask

    // sample every cycle of a detected frame at the falling edge; a reset abandons it
    logic [39:0] got_f;
    int          st;
    bit          abort;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                st = cyc;
                abort = 0;
                got_f = '0;
                for (int c = 1; c < 40; c++) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1;
                        break;
                    end
                    got_f[c] = tx;
                end
                if (!abort) begin
                    start_q.push_back(st);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got %h required none", got_f);
                    end else chk("frame", got_f, frame(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    int e;
    initial begin
        tv[0]  = '{32'd1, 1, 1, 0, 1};
        tv[1]  = '{32'd2, 1, 1, 0, 1};
        tv[2]  = '{32'd3, 1, 2, 0, 1};
        tv[3]  = '{32'd4, 1, 3, 0, 1};
        tv[4]  = '{32'd5, 1, 4, 0, 1};
        tv[5]  = '{32'd5, 0, 4, 0, 1};
        tv[6]  = '{32'd10, 1, 1, 0, 1};
        tv[7]  = '{32'd11, 1, 1, 0, 1};
        tv[8]  = '{32'd12, 1, 2, 0, 1};
        tv[9]  = '{32'd13, 1, 3, 0, 1};
        tv[10] = '{32'd14, 1, 4, 0, 1};
        tv[11] = '{32'd15, 0, 4, 1, 1};
        tv[12] = '{32'd15, 0, 4, 1, 1};
        rst = 1'b1;
        a0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_no_frame", start_q.size(), 0);

        a0 = 32'h12345678;
        push_word(a0);
        @(negedge clk);
        e = cyc;
        chk("single_level", level, 1);
        repeat (160) @(negedge clk);
        chk("single_busy_end", busy, 1);
        @(negedge clk);
        chk("single_busy_fall", busy, 0);
        chk("single_tx_idle", tx, 1);
        chk("single_bytes", start_q.size(), 4);
        if (start_q.size() == 4) begin
            chk("single_latency", start_q[0], e + 1);
            chk("single_span", start_q[3] - start_q[0], 120);
        end

        start_q.delete();
        run_vecs(0, 5, "burst");
        drain(2000);
        chk("burst_bytes", start_q.size(), 20);
        if (start_q.size() == 20)
            for (int k = 1; k < 5; k++) chk("burst_spacing", start_q[4*k] - start_q[4*k-4], 161);

        run_vecs(6, 12, "ovf");
        drain(2000);
        chk("ovf_sticky", overflow, 1);
        rst = 1'b1;
        a0 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", overflow, 0);
        chk("ovf_rst_level", level, 0);

        a0 = 32'hDEAD0001;
        push_word(a0);
        @(negedge clk);
        e = cyc;
        for (int k = 1; k <= 4; k++) begin
            a0 = 32'hC0DE0000 + 32'(k);
            push_word(a0);
            @(negedge clk);
        end
        while (cyc < e + 161) @(negedge clk);
        chk("full_level_before", level, 4);
        a0 = 32'h5555AAAA;
        push_word(a0);
        @(negedge clk);
        chk("full_level_after", level, 4);
        chk("full_ovf", overflow, 0);
        drain(2000);
        chk("full_ovf_end", overflow, 0);

        a0 = 32'hA5C30F96;
        push_word(a0);
        @(negedge clk);
        e = cyc;
        while (cyc < e + 58) @(negedge clk);
        rst = 1'b1;
        a0 = '0;
        @(negedge clk);
        exp_q.delete();
        chk("midrst_tx", tx, 1);
        chk("midrst_level", level, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_quiet", busy, 0);
        a0 = 32'h0BADF00D;
        push_word(a0);
        drain(400);
        chk("midrst_tx_idle", tx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
